// File: rtl/inst_fetch_bridge.sv
// Single-outstanding fetch bridge: turns each accepted PC into one single-beat AXI INCR read.
// Define INST_FETCH_PREFETCH_EN to add a one-entry next-sequential prefetch buffer.
module inst_fetch_bridge #(
    parameter int ARADDR_WIDTH = 40,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                    cpu_clk,
    input  logic                    cpu_reset,
    input  logic [31:0]             PC,
    input  logic                    Inst_Req_Valid,
    output logic                    Inst_Req_Ready,
    output logic [DATA_WIDTH-1:0]   Instruction,
    output logic                    Inst_Valid,
    input  logic                    Inst_Ready,
    output logic [ARADDR_WIDTH-1:0] cpu_inst_araddr,
    output logic                    cpu_inst_arvalid,
    input  logic                    cpu_inst_arready,
    output logic [2:0]              cpu_inst_arsize,
    output logic [1:0]              cpu_inst_arburst,
    output logic [7:0]              cpu_inst_arlen,
    input  logic [DATA_WIDTH-1:0]   cpu_inst_rdata,
    input  logic                    cpu_inst_rvalid,
    output logic                    cpu_inst_rready,
    input  logic                    cpu_inst_rlast
);

`ifdef INST_FETCH_PREFETCH_EN
    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_DONE, S_PF_AR, S_PF_R} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;
`endif

    state_t                state_q, state_d;
    logic [31:0]           pc_q, pc_d;
    logic [DATA_WIDTH-1:0] inst_q, inst_d;
    logic [31:0]           ar_addr;

`ifdef INST_FETCH_PREFETCH_EN
    logic [31:0]           pf_addr_q, pf_addr_d;
    logic [DATA_WIDTH-1:0] pf_data_q, pf_data_d;
    logic                  pf_valid_q, pf_valid_d;

    // The prefetch read uses its own address so pc_q keeps naming the delivered word.
    assign ar_addr = (state_q == S_PF_AR) ? pf_addr_q : pc_q;
`else
    assign ar_addr = pc_q;
`endif

    assign cpu_inst_araddr  = ARADDR_WIDTH'(ar_addr);
    assign cpu_inst_arsize  = 3'b010;
    assign cpu_inst_arburst = 2'b01;
    assign cpu_inst_arlen   = 8'd0;
    assign Instruction      = inst_q;

    always_ff @(posedge cpu_clk) begin
        if (cpu_reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            inst_q  <= '0;
`ifdef INST_FETCH_PREFETCH_EN
            pf_addr_q  <= '0;
            pf_data_q  <= '0;
            pf_valid_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
`ifdef INST_FETCH_PREFETCH_EN
            pf_addr_q  <= pf_addr_d;
            pf_data_q  <= pf_data_d;
            pf_valid_q <= pf_valid_d;
`endif
        end
    end

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        inst_d           = inst_q;
        Inst_Req_Ready   = 1'b0;
        Inst_Valid       = 1'b0;
        cpu_inst_arvalid = 1'b0;
        cpu_inst_rready  = 1'b0;
`ifdef INST_FETCH_PREFETCH_EN
        pf_addr_d  = pf_addr_q;
        pf_data_d  = pf_data_q;
        pf_valid_d = pf_valid_q;
`endif
        case (state_q)
            S_IDLE: begin
                Inst_Req_Ready = 1'b1;
                if (Inst_Req_Valid) begin
                    pc_d    = PC;
                    state_d = S_AR;
`ifdef INST_FETCH_PREFETCH_EN
                    // Any request consumes the buffer: a hit uses it, a miss discards it.
                    pf_valid_d = 1'b0;
                    if (pf_valid_q && (PC == pf_addr_q)) begin
                        inst_d  = pf_data_q;
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_AR: begin
                cpu_inst_arvalid = 1'b1;
                if (cpu_inst_arready) state_d = S_R;
            end
            S_R: begin
                cpu_inst_rready = 1'b1;
                // Beats without rlast are dropped; only the closing beat carries the word.
                if (cpu_inst_rvalid && cpu_inst_rlast) begin
                    inst_d  = cpu_inst_rdata;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                Inst_Valid = 1'b1;
                if (Inst_Ready) begin
`ifdef INST_FETCH_PREFETCH_EN
                    pf_addr_d  = pc_q + 32'd4;
                    pf_valid_d = 1'b0;
                    state_d    = S_PF_AR;
`else
                    state_d = S_IDLE;
`endif
                end
            end
`ifdef INST_FETCH_PREFETCH_EN
            S_PF_AR: begin
                cpu_inst_arvalid = 1'b1;
                if (cpu_inst_arready) state_d = S_PF_R;
            end
            S_PF_R: begin
                cpu_inst_rready = 1'b1;
                if (cpu_inst_rvalid && cpu_inst_rlast) begin
                    pf_data_d  = cpu_inst_rdata;
                    pf_valid_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: doc/inst_fetch_bridge.md
# inst_fetch_bridge

Single-outstanding instruction-fetch bridge between the custom CPU's fetch handshake (PC / Instruction) and the AXI read-only instruction port feeding the 2x1 CPU-to-memory arbiter. It sits in the same slot as the non-cached instruction interface wrapper. It converts each accepted PC into one single-beat AXI INCR read and returns the fetched word to the core. An optional one-entry next-sequential prefetch buffer hides fetch latency for straight-line code.

## Interface
- ARADDR_WIDTH, 40, width of cpu_inst_araddr; upper bits above 32 driven 0
- DATA_WIDTH, 32, instruction/data width; only 32 supported
- cpu_clk  in  1  single clock for all logic
- cpu_reset  in  1  synchronous, active-high reset
- PC  in  32  fetch address, word aligned
- Inst_Req_Valid  in  1  fetch request valid
- Inst_Req_Ready  out  1  bridge can accept request
- Instruction  out  32  fetched word
- Inst_Valid  out  1  Instruction valid
- Inst_Ready  in  1  core accepts Instruction
- cpu_inst_araddr  out  ARADDR_WIDTH  read address = {0, pc_q}
- cpu_inst_arvalid  out  1  AR valid
- cpu_inst_arready  in  1  AR ready
- cpu_inst_arsize  out  3  constant 3'b010
- cpu_inst_arburst  out  2  constant 2'b01 (INCR)
- cpu_inst_arlen  out  8  constant 8'd0
- cpu_inst_rdata  in  32  read data
- cpu_inst_rvalid  in  1  R valid
- cpu_inst_rready  out  1  R ready
- cpu_inst_rlast  in  1  last beat

## Operation
- States: IDLE, AR, R, DONE; with prefetch also PF_AR, PF_R.
- IDLE: Inst_Req_Ready=1. On Inst_Req_Valid: latch PC into pc_q; go AR (or DONE on prefetch hit).
- AR: cpu_inst_arvalid=1, araddr from pc_q held stable; on arready go R.
- R: cpu_inst_rready=1; on rvalid&rlast latch rdata into Instruction, go DONE. rvalid without rlast: data ignored, stay in R (protocol error tolerance).
- DONE: Inst_Valid=1, Instruction stable; on Inst_Ready go IDLE (or PF_AR with prefetch).
- Inst_Req_Ready is 1 only in IDLE; exactly one AXI read outstanding at any time.
- rresp is not checked; data delivered regardless.
- PC+4 computed modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.

## Timing
- Reset (cycle after cpu_reset sampled high): state IDLE; Inst_Req_Ready=1 on the following cycle; Inst_Valid=0, arvalid=0, rready=0, Instruction=0, araddr=0, prefetch buffer invalid. Reset mid-transaction abandons it; a late rvalid after reset is ignored (rready=0).
- Miss path: request accepted at edge 0; arvalid high in cycle 1; with arready in cycle 1, rready high in cycle 2; rvalid in cycle 2 gives Inst_Valid in cycle 3. Minimum accept-to-Inst_Valid = 3 cycles.
- Inst_Valid held until Inst_Ready; Inst_Valid&Inst_Ready at edge N gives Inst_Req_Ready=1 in cycle N+1 (non-prefetch).
- arvalid never deasserts before arready; araddr/arsize/arlen/arburst constant while arvalid.

## Configuration
- INST_FETCH_PREFETCH_EN defined: after each DONE handshake the bridge enters PF_AR/PF_R and reads pc_q+4 into pf_data/pf_addr, setting pf_valid. Inst_Req_Ready=0 during PF_AR/PF_R. In IDLE, a request with PC==pf_addr and pf_valid is a hit: Inst_Valid next cycle with pf_data, no AXI traffic, pf_valid cleared. A request that misses clears pf_valid and takes the miss path. Instruction memory is not snooped, so code written by stores is not guaranteed visible until the next miss.
- Undefined: PF states, pf_* registers and hit logic are absent; DONE returns directly to IDLE.

## Test plan
- Reset then PC=0x0000_0000 request, arready/rvalid always 1, rdata=0x0000_0013 -> araddr=0x00_0000_0000, arlen=0, arsize=2, Instruction=0x0000_0013 with Inst_Valid exactly 3 cycles after accept.
- Backpressure: arready low for 5 cycles, rvalid low for 4, Inst_Ready low for 3 -> arvalid/araddr stable throughout, Instruction held, no second AR issued, Inst_Req_Ready=0 until handshake.
- Reset asserted while in R with AR accepted -> next cycle all valids 0; rvalid pulse afterwards not consumed; new fetch of PC=0x100 returns correct data.
- Prefetch (EN): fetch 0x1000 then 0x1004 -> one extra AR at 0x1004 after the first handshake; second fetch has Inst_Valid 1 cycle after accept with no new AR.
- Prefetch miss/wrap (EN): fetch 0xFFFF_FFFC -> prefetch AR to 0x0; then fetch 0x2000 -> pf discarded, AR at 0x2000, correct data returned.
- Back-to-back 100 random aligned PCs against the pseudo-random-stalled RAM -> every Instruction matches memory image, in order, one per request.
